// File: rtl/ln_unit.sv
// ln_unit -- pipelined natural logarithm of an unsigned Q16.16 operand.
//
// Computes lnF = ln(F) as signed Q16.16 with a fixed 4-cycle latency and a
// throughput of one operand per clock. There is no handshake.
//   Stage 1: find the leading one of F, giving exponent e = p - 16 and a
//            left-normalised mantissa fraction m in [0,1).
//   Stage 2: log2(1+m) by linear interpolation in a 64-entry table.
//   Stage 3: log2(F) = e + log2(1+m), held as signed Q6.20.
//   Stage 4: multiply by ln2 (0xB172, Q0.16) and scale to Q16.16.
// An input of F = 0 yields the saturated value 0x80000000.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset; clears every pipeline register
//   F    in   DATA_WIDTH operand, unsigned Q16.16
//   lnF  out  DATA_WIDTH result, signed Q16.16, registered
//
// Build option:
//   LN_ROUND_EN  defined   -> the stage-4 scaling rounds to nearest (half up)
//                undefined -> the stage-4 scaling truncates toward -infinity
//
// Only DATA_WIDTH = 32 is supported.

module ln_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] F,
    output logic [DATA_WIDTH-1:0] lnF
);

    // ln(2) in Q0.16, carried as a positive signed constant.
    localparam logic signed [17:0] LN2_Q16 = 18'sh0B172;
    // log2(2) in the table's Q1.20 format; upper end of the last segment.
    localparam logic [20:0] LOG2_TWO = 21'h100000;

    // log2(1 + idx/64) in Q1.20, evaluated at elaboration time with the
    // square-and-compare method: squaring y doubles its log, so each
    // squaring that crosses 2.0 yields one more result bit. y is Q1.31.
    // Two guard bits are produced and then rounded off.
    function automatic logic [20:0] lut_val(input int idx);
        logic [63:0] y;
        logic [21:0] r;
        y = 64'(64 + idx) << 25;
        r = '0;
        for (int b = 21; b >= 0; b--) begin
            y = (y * y) >> 31;
            if (y >= 64'h1_0000_0000) begin
                r[b] = 1'b1;
                y    = y >> 1;
            end
        end
        return 21'((23'(r) + 23'd2) >> 2);
    endfunction

    logic [20:0] lut [0:63];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lut
            localparam logic [20:0] LUT_VAL = lut_val(gi);
            assign lut[gi] = LUT_VAL;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Stage 1: leading-one detection and normalisation
    // ---------------------------------------------------------------
    logic [4:0]  lead_pos;
    logic [31:0] norm;
    logic [5:0]  exp1_d;
    logic [21:0] mant1_d;
    logic        zero1_d;

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 32; i++) begin
            if (F[i]) begin
                lead_pos = 5'(i);
            end
        end
    end

    // Shift the leading one up to bit 31; the 22 bits beneath it are the
    // mantissa fraction (6 index bits + 16 interpolation-weight bits).
    assign norm    = F << (5'd31 - lead_pos);
    assign mant1_d = 22'(norm >> 9);
    assign exp1_d  = {1'b0, lead_pos} - 6'd16;
    assign zero1_d = (F == '0);

    logic [5:0]  exp1_q;
    logic [21:0] mant1_q;
    logic        zero1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp1_q  <= '0;
            mant1_q <= '0;
            zero1_q <= 1'b0;
        end else begin
            exp1_q  <= exp1_d;
            mant1_q <= mant1_d;
            zero1_q <= zero1_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: table interpolation of log2(1+m)
    // ---------------------------------------------------------------
    logic [5:0]  lut_idx;
    logic [15:0] lut_w;
    logic [20:0] t_lo;
    logic [20:0] t_hi;
    logic [20:0] t_diff;
    logic [36:0] interp_prod;
    logic [20:0] frac2_d;

    assign lut_idx = mant1_q[21:16];
    assign lut_w   = mant1_q[15:0];
    assign t_lo    = lut[lut_idx];
    // The last segment ends at log2(2) = 1.0, which is not a table entry.
    assign t_hi    = (lut_idx == 6'd63) ? LOG2_TWO : lut[lut_idx + 6'd1];
    assign t_diff  = t_hi - t_lo;
    assign interp_prod = 37'(t_diff) * 37'(lut_w);
    // Result stays strictly below t_hi <= 1.0, so 21 bits never overflow.
    assign frac2_d = t_lo + 21'(interp_prod >> 16);

    logic [5:0]  exp2_q;
    logic [20:0] frac2_q;
    logic        zero2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp2_q  <= '0;
            frac2_q <= '0;
            zero2_q <= 1'b0;
        end else begin
            exp2_q  <= exp1_q;
            frac2_q <= frac2_d;
            zero2_q <= zero1_q;
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: log2(F) = e + log2(1+m), signed Q6.20 in 27 bits
    // ---------------------------------------------------------------
    logic signed [26:0] log2_d;

    // Range is [-16, 16); one spare integer bit keeps the sum safe.
    assign log2_d = $signed({exp2_q[5], exp2_q, 20'b0}) + $signed({6'b0, frac2_q});

    logic signed [26:0] log2_q;
    logic               zero3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log2_q  <= '0;
            zero3_q <= 1'b0;
        end else begin
            log2_q  <= log2_d;
            zero3_q <= zero2_q;
        end
    end

    // ---------------------------------------------------------------
    // Stage 4: scale by ln2 to Q16.16
    // ---------------------------------------------------------------
    // Q6.20 * Q0.16 = Q.36; dropping 20 fraction bits leaves Q16.16.
    // |product| < 2^40, so 45 signed bits hold it with margin.
    logic signed [44:0] ln_prod;
    logic [31:0]        ln_scaled;
    logic [31:0]        lnf_d;

    assign ln_prod = log2_q * LN2_Q16;

`ifdef LN_ROUND_EN
    assign ln_scaled = 32'((ln_prod + (45'sd1 <<< 19)) >>> 20);
`else
    assign ln_scaled = 32'(ln_prod >>> 20);
`endif

    assign lnf_d = zero3_q ? 32'h8000_0000 : ln_scaled;

    logic [31:0] lnf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lnf_q <= '0;
        end else begin
            lnf_q <= lnf_d;
        end
    end

    assign lnF = DATA_WIDTH'(lnf_q);

endmodule

// File: tb/tb_ln_unit.sv
module tb_ln_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] F   = 32'h0;
    logic [31:0] lnF;

    ln_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .F   (F),
        .lnF (lnF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        int          exp_val;
        int          tol;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference: real-valued natural log, rounded to the nearest Q16.16 LSB.
    function automatic int model_ln(input logic [31:0] f);
        real x;
        if (f == 32'h0) return int'(32'h8000_0000);
        x = real'(f) / 65536.0;
        return int'($ln(x) * 65536.0);
    endfunction

    task automatic check_result(input exp_t e, input string tag);
        longint d;
        bit     ok;
        d = longint'($signed(lnF)) - longint'(e.exp_val);
        if (d < 0) d = -d;
        ok = (d <= longint'(e.tol));
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s F=%h lnF=%h required=%h tol=%0d", tag, e.f, lnF, e.exp_val, e.tol);
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        assert (lnF === 32'h0) else begin
            bad++;
            $error("FAIL %s lnF=%h required=00000000", tag, lnF);
        end
    endtask

    // After reset the pipeline holds zeros: the first three outputs are 0.
    task automatic prefill();
        exp_t z;
        exp_q.delete();
        tag_q.delete();
        z.f = 32'h0; z.exp_val = 0; z.tol = 0;
        repeat (3) begin
            exp_q.push_back(z);
            tag_q.push_back("pipe_flush");
        end
    endtask

    // Drive one operand; the result for the operand sampled three edges
    // earlier is checked just after this edge.
    task automatic step(input logic [31:0] f, input int exp_val, input int tol, input string tag);
        exp_t e;
        exp_t c;
        string t;
        F = f;
        @(posedge clk);
        e.f = f; e.exp_val = exp_val; e.tol = tol;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        if (exp_q.size() >= 4) begin
            c = exp_q.pop_front();
            t = tag_q.pop_front();
            check_result(c, t);
            $display("tx %s F=%h lnF=%h exp=%h", t, c.f, lnF, c.exp_val);
        end
    endtask

    task automatic step_rand();
        logic [31:0] f;
        f = $urandom >> $urandom_range(0, 31);
        step(f, model_ln(f), 8, "random");
    endtask

    initial begin
        logic [31:0] one;
        one = 32'h1;

        // Reset state
        rst = 1'b1;
        #1;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        prefill();

        // Directed reference points
        step(32'h0013_3E18, 32'h0002_F506, 8, "ln_19_24");
        step(32'h0001_0000, 32'h0000_0000, 0, "ln_one");
        step(32'h0002_0000, 32'h0000_B172, 1, "ln_two");
        step(32'h0000_8000, 32'hFFFF_4E8E, 1, "ln_half");
        step(32'h0000_0000, 32'h8000_0000, 0, "ln_zero");
        step(32'hFFFF_FFFF, 32'h000B_1721, 8, "ln_max");
        step(32'h0000_0001, 32'hFFF4_E8DF, 8, "ln_min");

        // Back-to-back changing operands
        step(32'h0000_0001, 32'hFFF4_E8DF, 8, "b2b_min");
        step(32'h0001_0000, 32'h0000_0000, 0, "b2b_one");
        step(32'hFFFF_FFFF, 32'h000B_1721, 8, "b2b_max");
        step(32'h0013_3E18, 32'h0002_F506, 8, "b2b_19_24");

        // Every exact power of two
        for (int k = 0; k < 32; k++) begin
            step(one << k, (k - 16) * 45426, 1, "pow2");
        end

        for (int i = 0; i < 15000; i++) begin
            step_rand();
        end

        // Reset mid-stream: output must clear without a clock edge
        step(32'hFFFF_FFFF, 32'h000B_1721, 8, "pre_reset");
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        prefill();

        step(32'h0002_0000, 32'h0000_B172, 1, "post_reset_two");
        step(32'h0000_0000, 32'h8000_0000, 0, "post_reset_zero");
        for (int i = 0; i < 15000; i++) begin
            step_rand();
        end

        // Flush the last operands through the pipeline
        repeat (3) step_rand();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
